// File: rtl/lcd_line_scanout_if.sv
// Bundles the line-buffer read port, ready/release handshake and LCD panel pins of the
// line scanout block. The master side is the scanout engine; the slave side is its environment.
interface lcd_line_scanout_if #(
    parameter int unsigned LINE_BITS = 1280,
    parameter int unsigned BUS_WIDTH = 4
);
    localparam int unsigned WORDS = LINE_BITS / BUS_WIDTH;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic                 i_enable;
    logic                 i_buf1_ready;
    logic                 i_buf2_ready;
    logic                 o_rd_sel;
    logic [AW-1:0]        o_rd_addr;
    logic [BUS_WIDTH-1:0] i_rd_data;
    logic                 o_buf1_release;
    logic                 o_buf2_release;
    logic [BUS_WIDTH-1:0] o_lcd_data;
    logic                 o_lcd_cp;
    logic                 o_lcd_lp;
    logic                 o_lcd_flm;
    logic                 o_frame_done;
    logic                 o_underrun;

    modport master (
        input  i_enable, i_buf1_ready, i_buf2_ready, i_rd_data,
        output o_rd_sel, o_rd_addr, o_buf1_release, o_buf2_release,
        output o_lcd_data, o_lcd_cp, o_lcd_lp, o_lcd_flm, o_frame_done, o_underrun
    );

    modport slave (
        output i_enable, i_buf1_ready, i_buf2_ready, i_rd_data,
        input  o_rd_sel, o_rd_addr, o_buf1_release, o_buf2_release,
        input  o_lcd_data, o_lcd_cp, o_lcd_lp, o_lcd_flm, o_frame_done, o_underrun
    );
endinterface

// File: rtl/lcd_line_scanout.sv
// Passive-matrix LCD line scanout. Consumes ping-pong line buffers in strict alternation,
// shifts each line out BUS_WIDTH bits per CP period, latches it with LP (FLM on line 0)
// and hands the buffer back with a one-cycle release pulse. Read data is sampled on the
// clock edge that ends the cycle in which its address is presented.
module lcd_line_scanout #(
    parameter int unsigned LINE_BITS = 1280,
    parameter int unsigned BUS_WIDTH = 4,
    parameter int unsigned LINES     = 1024,
    parameter int unsigned CP_DIV    = 2,
    parameter int unsigned LP_WIDTH  = 4
) (
    input logic               i_clk,
    input logic               i_reset_n,
    lcd_line_scanout_if.master bus
);
    localparam int unsigned WORDS = LINE_BITS / BUS_WIDTH;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LW    = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [AW-1:0] LastWord = AW'(WORDS - 1);
    localparam logic [LW-1:0] LastLine = LW'(LINES - 1);
    localparam logic [15:0]   DivLast  = 16'(CP_DIV - 1);
    localparam logic [15:0]   LpLast   = 16'(LP_WIDTH - 1);

    typedef enum logic [2:0] {StIdle, StWait, StFetch, StShift, StLatch, StRelease} state_e;

    logic [1:0] rst_sync_q;
    logic       rst_n;
    logic [1:0] rdy1_sync_q, rdy2_sync_q;
    logic       rdy1_s, rdy2_s, go;

    state_e               state_q, state_d;
    logic                 armed1_q, armed1_d, armed2_q, armed2_d;
    logic                 exp_sel_q, exp_sel_d;
    logic                 from_rel_q, from_rel_d;
    logic [LW-1:0]        line_q, line_d;
    logic [AW-1:0]        word_q, word_d;
    logic [15:0]          div_q, div_d;
    logic                 cp_hi_q, cp_hi_d;
    logic [15:0]          lp_cnt_q, lp_cnt_d;
    logic                 rd_sel_q, rd_sel_d;
    logic [AW-1:0]        rd_addr_q, rd_addr_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 cp_q, cp_d, lp_q, lp_d, flm_q, flm_d;
    logic                 rel1_q, rel1_d, rel2_q, rel2_d;
    logic                 frame_done_q, frame_done_d;
    logic                 underrun_q, underrun_d;

    // Reset synchroniser: asserts asynchronously, releases two clocks later.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Two-flop synchronisers for the ready levels from the ingester clock domain.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy1_sync_q <= 2'b00;
            rdy2_sync_q <= 2'b00;
        end else begin
            rdy1_sync_q <= {rdy1_sync_q[0], bus.i_buf1_ready};
            rdy2_sync_q <= {rdy2_sync_q[0], bus.i_buf2_ready};
        end
    end
    assign rdy1_s = rdy1_sync_q[1];
    assign rdy2_s = rdy2_sync_q[1];

    // Only the expected buffer may start a line, and only once its stale flag has dropped.
    assign go = exp_sel_q ? (armed2_q & rdy2_s) : (armed1_q & rdy1_s);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        armed1_d     = armed1_q | ~rdy1_s;
        armed2_d     = armed2_q | ~rdy2_s;
        exp_sel_d    = exp_sel_q;
        from_rel_d   = from_rel_q;
        line_d       = line_q;
        word_d       = word_q;
        div_d        = div_q;
        cp_hi_d      = cp_hi_q;
        lp_cnt_d     = lp_cnt_q;
        rd_sel_d     = rd_sel_q;
        rd_addr_d    = rd_addr_q;
        data_d       = data_q;
        cp_d         = cp_q;
        lp_d         = lp_q;
        flm_d        = flm_q;
        rel1_d       = 1'b0;
        rel2_d       = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = underrun_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_enable) state_d = StWait;
            end
            StWait: begin
                from_rel_d = 1'b0;
                if (go) begin
                    state_d   = StFetch;
                    rd_addr_d = '0;
                    rd_sel_d  = exp_sel_q;
                end else if (from_rel_q) begin
                    underrun_d = 1'b1;
                end
            end
            StFetch: begin
                data_d  = bus.i_rd_data;
                word_d  = '0;
                div_d   = '0;
                cp_hi_d = 1'b0;
                state_d = StShift;
            end
            StShift: begin
                if (div_q != DivLast) begin
                    div_d = div_q + 16'd1;
                end else begin
                    div_d = '0;
                    if (!cp_hi_q) begin
                        // Rising CP: prefetch the next word, but never past the line end.
                        cp_hi_d = 1'b1;
                        cp_d    = 1'b1;
                        if (word_q != LastWord) rd_addr_d = word_q + AW'(1);
                    end else begin
                        cp_hi_d = 1'b0;
                        cp_d    = 1'b0;
                        if (word_q == LastWord) begin
                            state_d  = StLatch;
                            data_d   = '0;
                            lp_d     = 1'b1;
                            flm_d    = (line_q == '0);
                            lp_cnt_d = '0;
                        end else begin
                            word_d = word_q + AW'(1);
                            data_d = bus.i_rd_data;
                        end
                    end
                end
            end
            StLatch: begin
                if (lp_cnt_q != LpLast) begin
                    lp_cnt_d = lp_cnt_q + 16'd1;
                end else begin
                    lp_d         = 1'b0;
                    flm_d        = 1'b0;
                    rel1_d       = ~rd_sel_q;
                    rel2_d       = rd_sel_q;
                    frame_done_d = (line_q == LastLine);
                    state_d      = StRelease;
                end
            end
            StRelease: begin
                exp_sel_d = ~exp_sel_q;
                line_d    = (line_q == LastLine) ? '0 : line_q + LW'(1);
                if (rd_sel_q) armed2_d = 1'b0;
                else          armed1_d = 1'b0;
                if (bus.i_enable) begin
                    state_d    = StWait;
                    from_rel_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            armed1_q     <= 1'b1;
            armed2_q     <= 1'b1;
            exp_sel_q    <= 1'b0;
            from_rel_q   <= 1'b0;
            line_q       <= '0;
            word_q       <= '0;
            div_q        <= '0;
            cp_hi_q      <= 1'b0;
            lp_cnt_q     <= '0;
            rd_sel_q     <= 1'b0;
            rd_addr_q    <= '0;
            data_q       <= '0;
            cp_q         <= 1'b0;
            lp_q         <= 1'b0;
            flm_q        <= 1'b0;
            rel1_q       <= 1'b0;
            rel2_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed1_q     <= armed1_d;
            armed2_q     <= armed2_d;
            exp_sel_q    <= exp_sel_d;
            from_rel_q   <= from_rel_d;
            line_q       <= line_d;
            word_q       <= word_d;
            div_q        <= div_d;
            cp_hi_q      <= cp_hi_d;
            lp_cnt_q     <= lp_cnt_d;
            rd_sel_q     <= rd_sel_d;
            rd_addr_q    <= rd_addr_d;
            data_q       <= data_d;
            cp_q         <= cp_d;
            lp_q         <= lp_d;
            flm_q        <= flm_d;
            rel1_q       <= rel1_d;
            rel2_q       <= rel2_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.o_rd_sel       = rd_sel_q;
    assign bus.o_rd_addr      = rd_addr_q;
    assign bus.o_buf1_release = rel1_q;
    assign bus.o_buf2_release = rel2_q;
    assign bus.o_lcd_data     = data_q;
    assign bus.o_lcd_cp       = cp_q;
    assign bus.o_lcd_lp       = lp_q;
    assign bus.o_lcd_flm      = flm_q;
    assign bus.o_frame_done   = frame_done_q;
    assign bus.o_underrun     = underrun_q;
endmodule

// File: tb/tb_lcd_line_scanout.sv
// Directed bench for lcd_line_scanout with a scoreboard of expected CP words, LP/FLM events
// and buffer releases, checked by a negedge monitor.
module tb_lcd_line_scanout;
    localparam int unsigned LINE_BITS = 16;
    localparam int unsigned BUS_WIDTH = 4;
    localparam int unsigned LINES     = 3;
    localparam int unsigned CP_DIV    = 1;
    localparam int unsigned LP_WIDTH  = 2;

    typedef struct packed {logic [3:0] data; logic [1:0] addr;} word_t;
    typedef struct packed {logic sel; logic fd;} rel_t;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    lcd_line_scanout_if #(.LINE_BITS(LINE_BITS), .BUS_WIDTH(BUS_WIDTH)) bus ();

    lcd_line_scanout #(
        .LINE_BITS(LINE_BITS), .BUS_WIDTH(BUS_WIDTH), .LINES(LINES),
        .CP_DIV(CP_DIV), .LP_WIDTH(LP_WIDTH)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .bus      (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] mem1 = 16'h0, mem2 = 16'h0;
    int n_tests = 0, n_fail = 0;
    int cp_edges = 0;
    int lp_len = 0;
    logic cp_prev = 1'b0, lp_prev = 1'b0;
    word_t wq[$];
    logic  fq[$];
    rel_t  rq[$];

    // Buffer memories: data for the presented address, sampled by the DUT at the next edge.
    always_comb begin
        logic [15:0] line;
        line = bus.o_rd_sel ? mem2 : mem1;
        line = line >> (12 - 4 * int'(bus.o_rd_addr));
        bus.i_rd_data = line[3:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [15:0] val, input logic flm, input logic sel,
                             input logic fd);
        for (int w = 0; w < 4; w++) begin
            word_t e;
            e.data = val[15 - 4 * w -: 4];
            e.addr = (w < 3) ? 2'(w + 1) : 2'd3;
            wq.push_back(e);
        end
        fq.push_back(flm);
        rq.push_back('{sel: sel, fd: fd});
    endtask

    task automatic wait_release(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge i_clk);
            if (bus.o_buf1_release || bus.o_buf2_release) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_cp(input int target, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge i_clk);
            if (cp_edges >= target) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        wq.delete();
        fq.delete();
        rq.delete();
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    // Monitor: pop and compare scoreboard entries as the panel events occur.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            cp_prev = 1'b0;
            lp_prev = 1'b0;
            lp_len  = 0;
        end else begin
            if (bus.o_lcd_cp && !cp_prev) begin
                cp_edges++;
                chk("cp_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    word_t e;
                    e = wq.pop_front();
                    chk("cp_data", 32'(bus.o_lcd_data), 32'(e.data));
                    chk("cp_addr", 32'(bus.o_rd_addr), 32'(e.addr));
                end
            end
            if (bus.o_lcd_lp) lp_len++;
            if (bus.o_lcd_lp && !lp_prev) begin
                chk("lp_expected", 32'(fq.size() > 0), 32'd1);
                if (fq.size() > 0) chk("lp_flm", 32'(bus.o_lcd_flm), 32'(fq.pop_front()));
                chk("lp_cp_low", 32'(bus.o_lcd_cp), 32'd0);
                chk("lp_data_zero", 32'(bus.o_lcd_data), 32'd0);
            end
            if (!bus.o_lcd_lp && lp_prev) begin
                chk("lp_width", 32'(lp_len), 32'(LP_WIDTH));
                lp_len = 0;
            end
            if (bus.o_buf1_release || bus.o_buf2_release) begin
                chk("rel_expected", 32'(rq.size() > 0), 32'd1);
                if (rq.size() > 0) begin
                    rel_t r;
                    r = rq.pop_front();
                    chk("rel_buf1", 32'(bus.o_buf1_release), 32'(!r.sel));
                    chk("rel_buf2", 32'(bus.o_buf2_release), 32'(r.sel));
                    chk("frame_done", 32'(bus.o_frame_done), 32'(r.fd));
                end
            end
            cp_prev = bus.o_lcd_cp;
            lp_prev = bus.o_lcd_lp;
        end
    end

    initial begin
        int base;
        bus.i_enable     = 1'b0;
        bus.i_buf1_ready = 1'b0;
        bus.i_buf2_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_cp", 32'(bus.o_lcd_cp), 32'd0);
        chk("rst_lp", 32'(bus.o_lcd_lp), 32'd0);
        chk("rst_flm", 32'(bus.o_lcd_flm), 32'd0);
        chk("rst_data", 32'(bus.o_lcd_data), 32'd0);
        chk("rst_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("rst_underrun", 32'(bus.o_underrun), 32'd0);
        do_reset();

        // 1: single line from buffer1
        mem1 = 16'hA5C3;
        push_line(16'hA5C3, 1'b1, 1'b0, 1'b0);
        bus.i_enable     = 1'b1;
        bus.i_buf1_ready = 1'b1;
        wait_release("t1_release");
        bus.i_buf1_ready = 1'b0;

        // 2: both ready -> order 1,2,1 with frame wrap on the third line
        do_reset();
        mem1 = 16'h1234;
        mem2 = 16'h5678;
        push_line(16'h1234, 1'b1, 1'b0, 1'b0);
        push_line(16'h5678, 1'b0, 1'b1, 1'b0);
        bus.i_buf1_ready = 1'b1;
        bus.i_buf2_ready = 1'b1;
        wait_release("t2_release_a");
        bus.i_buf1_ready = 1'b0;
        wait_release("t2_release_b");
        bus.i_buf2_ready = 1'b0;
        mem1 = 16'h9ABC;
        push_line(16'h9ABC, 1'b0, 1'b0, 1'b1);
        bus.i_buf1_ready = 1'b1;
        wait_release("t2_release_c");
        bus.i_buf1_ready = 1'b0;

        // 3: stale buf1 flag never dropped -> stall in WAIT and underrun
        do_reset();
        chk("t3_underrun_clear", 32'(bus.o_underrun), 32'd0);
        mem1 = 16'h0FF0;
        push_line(16'h0FF0, 1'b1, 1'b0, 1'b0);
        bus.i_buf1_ready = 1'b1;
        wait_release("t3_release");
        base = cp_edges;
        repeat (20) @(negedge i_clk);
        chk("t3_stalled", 32'(cp_edges), 32'(base));
        chk("t3_underrun", 32'(bus.o_underrun), 32'd1);
        chk("t3_cp_low", 32'(bus.o_lcd_cp), 32'd0);
        chk("t3_lp_low", 32'(bus.o_lcd_lp), 32'd0);
        bus.i_buf1_ready = 1'b0;

        // 4: disable during word 1 -> line completes, IDLE, then resume with buffer2
        do_reset();
        mem1 = 16'h4B2E;
        mem2 = 16'h71D8;
        push_line(16'h4B2E, 1'b1, 1'b0, 1'b0);
        bus.i_buf1_ready = 1'b1;
        bus.i_buf2_ready = 1'b1;
        base = cp_edges;
        wait_cp(base + 2, "t4_word1");
        bus.i_enable = 1'b0;
        wait_release("t4_release_a");
        base = cp_edges;
        repeat (20) @(negedge i_clk);
        chk("t4_idle", 32'(cp_edges), 32'(base));
        chk("t4_idle_underrun", 32'(bus.o_underrun), 32'd0);
        push_line(16'h71D8, 1'b0, 1'b1, 1'b0);
        bus.i_enable = 1'b1;
        wait_release("t4_release_b");

        // 5: asynchronous reset mid-SHIFT, then line 0 from buffer1
        bus.i_buf1_ready = 1'b0;
        bus.i_buf2_ready = 1'b0;
        repeat (6) @(negedge i_clk);
        mem1 = 16'h0F0F;
        push_line(16'h0F0F, 1'b0, 1'b0, 1'b1);
        bus.i_buf1_ready = 1'b1;
        base = cp_edges;
        wait_cp(base + 2, "t5_midshift");
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("t5_cp", 32'(bus.o_lcd_cp), 32'd0);
        chk("t5_data", 32'(bus.o_lcd_data), 32'd0);
        chk("t5_addr", 32'(bus.o_rd_addr), 32'd0);
        chk("t5_sel", 32'(bus.o_rd_sel), 32'd0);
        chk("t5_underrun", 32'(bus.o_underrun), 32'd0);
        chk("t5_lp", 32'(bus.o_lcd_lp), 32'd0);
        wq.delete();
        fq.delete();
        rq.delete();
        mem1 = 16'h3C96;
        push_line(16'h3C96, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        wait_release("t5_release");

        repeat (4) @(negedge i_clk);
        chk("end_words_left", 32'(wq.size()), 32'd0);
        chk("end_lp_left", 32'(fq.size()), 32'd0);
        chk("end_rel_left", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
